// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit saturating direction counters,
//               combinational lookup, single update port and invalidate sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int DBITS = 16,
    parameter int ABITS = 6,
    parameter int TBITS = DBITS - ABITS - 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [DBITS-1:0] PC,
    output logic [DBITS-1:0] PREDPC,
    output logic             PREDTAKEN,
    output logic             HIT,
    output logic             READY,
    input  logic             INVAL,
    input  logic             UPD,
    input  logic [DBITS-1:0] UPDPC,
    input  logic [DBITS-1:0] UPDTARG,
    input  logic             UPDTAKEN
);

    localparam int c_ENTRIES = 2 ** ABITS;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ABITS-1:0]   r_swcnt;

    logic               r_valid [c_ENTRIES];
    logic [TBITS-1:0]   r_tag   [c_ENTRIES];
    logic [DBITS-1:0]   r_targ  [c_ENTRIES];
    logic [1:0]         r_cnt   [c_ENTRIES];

    logic [ABITS-1:0]   w_lk_idx;
    logic [TBITS-1:0]   w_lk_tag;
    logic [ABITS-1:0]   w_up_idx;
    logic [TBITS-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_upd_en;
    logic               w_unused_updpc0;

    assign w_lk_idx        = PC[ABITS:1];
    assign w_lk_tag        = PC[DBITS-1:ABITS+1];
    assign w_up_idx        = UPDPC[ABITS:1];
    assign w_up_tag        = UPDPC[DBITS-1:ABITS+1];
    assign w_unused_updpc0 = UPDPC[0];

    // Lookup: reads registered state only, so a same-cycle update is not seen
    assign READY     = (r_state == RUN);
    assign HIT       = READY & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign PREDTAKEN = HIT & r_cnt[w_lk_idx][1];
    assign PREDPC    = PREDTAKEN ? r_targ[w_lk_idx] : PC + DBITS'(2);

    // INVAL takes priority over a simultaneous update
    assign w_up_hit = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
    assign w_upd_en = UPD & READY & ~INVAL;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SWEEP: begin
                if (!INVAL && (r_swcnt == {ABITS{1'b1}})) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (INVAL) begin
                    w_state_nxt = SWEEP;
                end
            end
            default: w_state_nxt = SWEEP;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= SWEEP;
            r_swcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == SWEEP) && !INVAL) begin
                r_swcnt <= r_swcnt + ABITS'(1);
            end else begin
                r_swcnt <= '0;
            end
        end
    end

    // Valid bits are flops; reset alone leaves them untouched, the sweep clears them
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            if (r_state == SWEEP) begin
                r_valid[r_swcnt] <= 1'b0;
            end else if (w_upd_en && !w_up_hit && UPDTAKEN) begin
                r_valid[w_up_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN && w_upd_en) begin
            if (w_up_hit) begin
                if (UPDTAKEN) begin
                    r_targ[w_up_idx] <= UPDTARG;
                    if (r_cnt[w_up_idx] != 2'd3) begin
                        r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 2'd1;
                    end
                end else if (r_cnt[w_up_idx] != 2'd0) begin
                    r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 2'd1;
                end
            end else if (UPDTAKEN) begin
                r_tag[w_up_idx]  <= w_up_tag;
                r_targ[w_up_idx] <= UPDTARG;
                r_cnt[w_up_idx]  <= 2'd2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Scoreboard bench for branch_target_buffer (DBITS=16, ABITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    localparam int c_DBITS = 16;
    localparam int c_ABITS = 4;

    logic        clk;
    logic        rstn;
    logic [15:0] pc;
    logic [15:0] predpc;
    logic        predtaken;
    logic        hit;
    logic        ready;
    logic        inval;
    logic        upd;
    logic [15:0] updpc;
    logic [15:0] updtarg;
    logic        updtaken;

    branch_target_buffer #(
        .DBITS (c_DBITS),
        .ABITS (c_ABITS)
    ) u_dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .PC        (pc),
        .PREDPC    (predpc),
        .PREDTAKEN (predtaken),
        .HIT       (hit),
        .READY     (ready),
        .INVAL     (inval),
        .UPD       (upd),
        .UPDPC     (updpc),
        .UPDTARG   (updtarg),
        .UPDTAKEN  (updtaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        hit;
        logic        pt;
        logic [15:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model of the table
    logic        m_valid [16];
    logic [10:0] m_tag   [16];
    logic [15:0] m_targ  [16];
    logic [1:0]  m_cnt   [16];
    int          m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_lookup(input logic [15:0] a);
        exp_t e;
        logic [3:0] ix;
        ix    = a[4:1];
        e.rdy = (m_left == 0);
        e.hit = e.rdy && m_valid[ix] && (m_tag[ix] == a[15:5]);
        e.pt  = e.hit && m_cnt[ix][1];
        e.npc = e.pt ? m_targ[ix] : a + 16'd2;
        return e;
    endfunction

    // Drive inputs, push expected lookup, then compare after settling
    task automatic drive(input logic [15:0] a, input logic u, input logic [15:0] ua,
                         input logic [15:0] ut, input logic tk, input logic inv);
        exp_t e;
        pc = a; upd = u; updpc = ua; updtarg = ut; updtaken = tk; inval = inv;
        sb_q.push_back(model_lookup(a));
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ready",     {31'd0, ready},     {31'd0, e.rdy});
            chk("hit",       {31'd0, hit},       {31'd0, e.hit});
            chk("predtaken", {31'd0, predtaken}, {31'd0, e.pt});
            chk("predpc",    {16'd0, predpc},    {16'd0, e.npc});
        end
    endtask

    // Apply model state change for the coming edge, then clock it
    task automatic advance();
        logic [3:0] ix;
        ix = updpc[4:1];
        if (!rstn || inval) begin
            m_left = 16;
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (upd) begin
            if (m_valid[ix] && m_tag[ix] == updpc[15:5]) begin
                if (updtaken) begin
                    m_targ[ix] = updtarg;
                    if (m_cnt[ix] != 2'd3) m_cnt[ix] = m_cnt[ix] + 2'd1;
                end else if (m_cnt[ix] != 2'd0) begin
                    m_cnt[ix] = m_cnt[ix] - 2'd1;
                end
            end else if (updtaken) begin
                m_valid[ix] = 1'b1;
                m_tag[ix]   = updpc[15:5];
                m_targ[ix]  = updtarg;
                m_cnt[ix]   = 2'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [15:0] a, input logic u, input logic [15:0] ua,
                        input logic [15:0] ut, input logic tk, input logic inv);
        drive(a, u, ua, ut, tk, inv);
        advance();
    endtask

    initial begin
        rstn = 1'b0; pc = 16'h0200; upd = 1'b0; updpc = '0; updtarg = '0;
        updtaken = 1'b0; inval = 1'b0;
        m_left = 16;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_targ[i] = '0; m_cnt[i] = '0;
        end
        @(posedge clk); #1;

        // Reset sweep
        for (int i = 0; i < 3; i++) step(16'h0200, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) step(16'h0200, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(16'h0200, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("ready_after_sweep", {31'd0, ready}, 32'd1);
        chk("predpc_0200", {16'd0, predpc}, 32'h0202);
        advance();

        // Allocation
        step(16'h0200, 1'b1, 16'h0204, 16'h0240, 1'b1, 1'b0);
        drive(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("alloc_hit", {31'd0, hit}, 32'd1);
        chk("alloc_predpc", {16'd0, predpc}, 32'h0240);
        advance();

        // Counter hysteresis and saturation at both ends
        step(16'h0204, 1'b1, 16'h0204, 16'h0000, 1'b0, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0000, 1'b0, 1'b0);
        drive(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("nt2_predtaken", {31'd0, predtaken}, 32'd0);
        chk("nt2_hit", {31'd0, hit}, 32'd1);
        chk("nt2_predpc", {16'd0, predpc}, 32'h0206);
        advance();
        step(16'h0204, 1'b1, 16'h0204, 16'h0000, 1'b0, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0240, 1'b1, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0240, 1'b1, 1'b0);
        drive(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("t2_predtaken", {31'd0, predtaken}, 32'd1);
        advance();
        step(16'h0204, 1'b1, 16'h0204, 16'h0240, 1'b1, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0240, 1'b1, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0000, 1'b0, 1'b0);
        step(16'h0204, 1'b1, 16'h0204, 16'h0000, 1'b0, 1'b0);
        step(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Aliasing on index 2
        step(16'h0200, 1'b1, 16'h0224, 16'h0260, 1'b1, 1'b0);
        drive(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("alias_old_hit", {31'd0, hit}, 32'd0);
        chk("alias_old_predpc", {16'd0, predpc}, 32'h0206);
        advance();
        step(16'h0224, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // INVAL with simultaneous UPD, then updates during the sweep
        step(16'h0300, 1'b1, 16'h0300, 16'h0310, 1'b1, 1'b0);
        step(16'h0300, 1'b1, 16'h0208, 16'h0280, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(i[0] ? 16'h0300 : 16'h0208, 1'b1, 16'h0208, 16'h0280, 1'b1, 1'b0);
        step(16'h0300, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(16'h0208, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("inval_upd_dropped", {31'd0, hit}, 32'd0);
        advance();
        step(16'h0224, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // PC wrap and same-cycle lookup/update hazard
        drive(16'hFFFE, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("wrap_predpc", {16'd0, predpc}, 32'h0000);
        advance();
        drive(16'h0204, 1'b1, 16'h0204, 16'h0250, 1'b1, 1'b0);
        chk("hazard_same_cycle", {31'd0, hit}, 32'd0);
        advance();
        drive(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("hazard_next_cycle", {31'd0, hit}, 32'd1);
        chk("hazard_predpc", {16'd0, predpc}, 32'h0250);
        advance();

        // INVAL during the sweep restarts it
        step(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(16'h0204, 1'b1, 16'h0204, 16'h0250, 1'b1, 1'b0);
        step(16'h0204, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Reset mid-run drops a pending update
        rstn = 1'b0;
        step(16'h0204, 1'b1, 16'h0300, 16'h0310, 1'b1, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) step(16'h0300, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
